id_inst_queue: RTL and testbench
================================

Name: id_inst_queue

Overview:
- Parametrised instruction buffer between fetch and decode; successor to the single-register fs_to_ds_bus/fs_ex_bus latch in decode.
- Decouples fetch from decode stalls (stallD, es_allowin backpressure) with a DEPTH-entry FIFO and a valid/allowin handshake on both sides.
- Adds what the single latch lacks: occupancy, an optional fall-through bypass, exception flush, and branch-redirect squash that preserves the delay slot.

Parameters:
- DATA_WD, 98, width of one entry = `FS_TO_DS_BUS_WD (64: inst, pc) + `FS_EX_BUS_WD (34: bd, adel, badvaddr).
- DEPTH, 4, number of entries; power of two, >= 2.
- BYPASS, 0, 1 = an entry pushed into an empty queue is presented to decode in the same cycle; 0 = minimum latency is one cycle.

Ports:
- clk, input, 1, clock.
- reset, input, 1, asynchronous active-high reset.
- fs_to_iq_valid, input, 1, fetch offers an entry.
- fs_to_iq_bus, input, DATA_WD, {fs_ex_bus, fs_to_ds_bus}.
- iq_allowin, output, 1, queue can accept a push this cycle.
- iq_to_ds_valid, output, 1, head entry is valid.
- iq_to_ds_bus, output, DATA_WD, head entry.
- ds_allowin, input, 1, decode takes the head this cycle.
- flush, input, 1, CP0 exception/eret flush.
- br_redirect, input, 1, single-cycle pulse in the cycle decode hands a taken branch/jump to exe.
- iq_count, output, $clog2(DEPTH)+1, current occupancy.

Behaviour:
- Reset, asynchronous: rd_ptr = 0, wr_ptr = 0, count = 0, ds_pending = 0. Entry storage is not reset.
- Reset outputs: iq_to_ds_valid = 0, iq_count = 0, iq_allowin = 1.
- iq_allowin = (count != DEPTH) | ds_allowin, i.e. a push into a full queue is allowed when a pop occurs in the same cycle.
- push = fs_to_iq_valid & iq_allowin. pop = iq_to_ds_valid & ds_allowin.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count updates +1 on push only, -1 on pop only, and holds on both or neither.
- BYPASS = 0 outputs:
  - iq_to_ds_valid = (count != 0); iq_to_ds_bus = mem[rd_ptr].
  - A push to an empty queue is visible in the next cycle.
- BYPASS = 1, when count == 0 and fs_to_iq_valid:
  - iq_to_ds_valid = 1 and iq_to_ds_bus = fs_to_iq_bus.
  - If ds_allowin is also high, the entry is consumed directly: no write, and pointers and count are unchanged.
- flush has the highest priority:
  - Next cycle: count = 0, rd_ptr = wr_ptr, ds_pending = 0.
  - A push in the flush cycle is discarded.
  - A pop in the flush cycle is still reported to decode, and decode's own flush drops it.
- br_redirect, when flush = 0. Let rem = count - pop, the entries left after this cycle's pop.
  - rem >= 1: keep only the oldest remaining entry (the delay slot). Next count = 1, wr_ptr = rd_ptr_next + 1, and any push this cycle is dropped.
  - rem == 0 with a push this cycle: keep the pushed entry as the delay slot. Next count = 1.
  - rem == 0 with no push: set ds_pending = 1. The next accepted push is kept, then ds_pending clears. ds_pending only changes the redirect bookkeeping; it never blocks a push.
  - With BYPASS = 1 and the queue empty, a push consumed directly in the redirect cycle counts as the delay slot and ds_pending stays 0.
- A second br_redirect while count == 1 and no pop occurs keeps that entry. This case is legal, because a branch in a delay slot is architecturally undefined and it must not corrupt state.
- Reset asserted mid-operation clears state immediately. Outputs drop in the same cycle because they are combinational from state.
- No combinational path from ds_allowin to iq_allowin when BYPASS = 0 and the queue is not full.

Decomposition:
- mycpu.h:
  - Add `IQ_BUS_WD (= `FS_TO_DS_BUS_WD + `FS_EX_BUS_WD) and `IQ_DEPTH (4).
  - Decode unpacks iq_to_ds_bus with the existing field order.
- No sub-module. Storage is a flat reg array inside the block; the pointer/count logic is small enough to keep inline.

Test Plan:
- Fill/drain, DEPTH = 4, BYPASS = 0:
  - Push pc 0xbfc00000..0xbfc0000c with ds_allowin = 0 -> iq_count reaches 4 and iq_allowin = 0.
  - Raise ds_allowin -> entries pop in order, one per cycle, and iq_to_ds_valid falls after the 4th.
- Full + simultaneous push/pop: count = 4, fs_to_iq_valid = 1, ds_allowin = 1 -> push accepted, count stays 4, wr_ptr wraps to 1 after 5 total pushes, data order preserved.
- BYPASS = 1 fall-through: empty queue, push pc 0x100 with ds_allowin = 1 -> iq_to_ds_bus pc = 0x100 in the same cycle, iq_count stays 0.
- Flush: count = 3 and a push in the same cycle as flush -> next cycle iq_count = 0, iq_to_ds_valid = 0, and the pushed entry never appears.
- br_redirect with entries: queue {0x200, 0x204, 0x208}, pop of 0x200 (the branch) with br_redirect, plus a push of 0x20c -> next cycle count = 1 and head pc = 0x204; 0x208 and 0x20c are never presented.
- br_redirect when empty: br_redirect with count = 0 and no push -> ds_pending = 1; the next push 0x304 is kept and ds_pending = 0; a later push 0x400 is also accepted and count = 2.
- Async reset mid-fill: count = 2, assert reset between clock edges -> iq_to_ds_valid = 0 and iq_count = 0 immediately.

Source files
------------

// File: rtl/id_inst_queue_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : id_inst_queue_pkg
//  Purpose  : Shared widths, entry layout and helpers for the fetch->decode
//             instruction queue.
//  Contents : bus width constants, packed entry struct, pointer-width helper.
//  Revision : 1.0 - initial release
// ============================================================================
package id_inst_queue_pkg;

  // Field widths of the two fetch-side buses that are concatenated per entry.
  localparam int FS_TO_DS_BUS_WD = 64;  // {inst, pc}
  localparam int FS_EX_BUS_WD    = 34;  // {bd, adel, badvaddr}
  localparam int IQ_BUS_WD       = FS_TO_DS_BUS_WD + FS_EX_BUS_WD;
  localparam int IQ_DEPTH        = 4;

  typedef struct packed {
    logic        bd;
    logic        adel;
    logic [31:0] badvaddr;
  } fs_ex_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fs_to_ds_t;

  // Matches {fs_ex_bus, fs_to_ds_bus}; pc sits in the low 32 bits.
  typedef struct packed {
    fs_ex_t    ex;
    fs_to_ds_t ds;
  } iq_entry_t;

  // Pointer width for a power-of-two depth; never narrower than one bit.
  function automatic int iq_ptr_wd(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage
`default_nettype wire

// File: rtl/id_inst_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : id_inst_queue
//  Purpose  : DEPTH-entry instruction FIFO between fetch and decode with
//             valid/allowin handshakes, optional fall-through bypass,
//             exception flush and branch-redirect squash that keeps the
//             delay-slot instruction.
//  Ports    : clk, reset (async, active high)
//             fs_to_iq_valid / fs_to_iq_bus / iq_allowin  - fetch side
//             iq_to_ds_valid / iq_to_ds_bus / ds_allowin  - decode side
//             flush        - CP0 exception/eret flush (highest priority)
//             br_redirect  - taken branch handed from decode to exe
//             iq_count     - current occupancy
//  Revision : 1.0 - initial release
// ============================================================================
module id_inst_queue
  import id_inst_queue_pkg::*;
#(
  parameter int DATA_WD = IQ_BUS_WD,
  parameter int DEPTH   = IQ_DEPTH,
  parameter int BYPASS  = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fs_to_iq_valid,
  input  logic [DATA_WD-1:0]         fs_to_iq_bus,
  output logic                       iq_allowin,
  output logic                       iq_to_ds_valid,
  output logic [DATA_WD-1:0]         iq_to_ds_bus,
  input  logic                       ds_allowin,
  input  logic                       flush,
  input  logic                       br_redirect,
  output logic [$clog2(DEPTH):0]     iq_count
);

  localparam int PTR_W = iq_ptr_wd(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [DATA_WD-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;
  logic               ds_pending;

  logic [PTR_W-1:0]   rd_ptr_nxt;
  logic [PTR_W-1:0]   wr_ptr_nxt;
  logic [CNT_W-1:0]   count_nxt;
  logic               ds_pending_nxt;
  logic               wr_en;

  // --------------------------------------------------------------------------
  // Handshake decode
  // --------------------------------------------------------------------------
  logic empty;
  logic full;
  logic bypass_hit;   // empty queue presenting the incoming entry directly
  logic push;
  logic pop;
  logic direct;       // entry passes straight through; storage untouched
  logic push_fifo;
  logic pop_fifo;
  logic rem_nz;       // entries remain after this cycle's pop
  logic [PTR_W-1:0] rd_ptr_pop;

  assign empty = (count == '0);
  assign full  = (count == FULL_COUNT);

  generate
    if (BYPASS != 0) begin : g_bypass
      assign bypass_hit   = empty & fs_to_iq_valid;
      assign iq_to_ds_bus = empty ? fs_to_iq_bus : mem[rd_ptr];
    end else begin : g_no_bypass
      assign bypass_hit   = 1'b0;
      assign iq_to_ds_bus = mem[rd_ptr];
    end
  endgenerate

  assign iq_to_ds_valid = ~empty | bypass_hit;
  // Only a full queue looks at ds_allowin, so no path exists otherwise.
  assign iq_allowin     = ~full | ds_allowin;
  assign iq_count       = count;

  assign push      = fs_to_iq_valid & iq_allowin;
  assign pop       = iq_to_ds_valid & ds_allowin;
  assign direct    = bypass_hit & ds_allowin;
  assign push_fifo = push & ~direct;
  assign pop_fifo  = pop & ~direct;

  assign rem_nz     = (count > CNT_W'(pop_fifo));
  assign rd_ptr_pop = rd_ptr + PTR_W'(pop_fifo);

  // --------------------------------------------------------------------------
  // Next-state: flush > redirect-with-survivors > normal push/pop
  // --------------------------------------------------------------------------
  always_comb begin
    rd_ptr_nxt     = rd_ptr_pop;
    wr_ptr_nxt     = wr_ptr;
    count_nxt      = count;
    ds_pending_nxt = ds_pending;
    wr_en          = 1'b0;

    if (flush) begin
      // The pop (if any) was already presented; decode discards it itself.
      rd_ptr_nxt     = wr_ptr;
      count_nxt      = '0;
      ds_pending_nxt = 1'b0;
    end else if (br_redirect && rem_nz) begin
      // Oldest surviving entry is the delay slot; everything younger,
      // including this cycle's push, is squashed.
      wr_ptr_nxt     = rd_ptr_pop + PTR_W'(1);
      count_nxt      = CNT_W'(1);
      ds_pending_nxt = 1'b0;
    end else begin
      wr_en      = push_fifo;
      wr_ptr_nxt = wr_ptr + PTR_W'(push_fifo);
      count_nxt  = count + CNT_W'(push_fifo) - CNT_W'(pop_fifo);
      if (push) begin
        // Any accepted push (stored or passed through) fills a pending slot,
        // and in a redirect cycle it is the delay slot itself.
        ds_pending_nxt = 1'b0;
      end else if (br_redirect) begin
        // Delay slot not fetched yet: remember that the next push is kept.
        ds_pending_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      ds_pending <= 1'b0;
    end else begin
      rd_ptr     <= rd_ptr_nxt;
      wr_ptr     <= wr_ptr_nxt;
      count      <= count_nxt;
      ds_pending <= ds_pending_nxt;
    end
  end

  // Entry storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= fs_to_iq_bus;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_id_inst_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_id_inst_queue
//  Purpose  : Self-checking bench for id_inst_queue. Two instances (BYPASS=0
//             and BYPASS=1) share one stimulus stream; each is compared every
//             cycle against a queue-based model of the queue's rules, and
//             directed scenarios pin literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_id_inst_queue;
  import id_inst_queue_pkg::*;

  localparam int DW  = 98;
  localparam int DEP = 4;

  logic              clk;
  logic              reset;
  logic              fs_valid;
  logic [DW-1:0]     fs_bus;
  logic              ds_allowin;
  logic              flush;
  logic              br;

  logic [1:0]        v;
  logic [1:0]        al;
  logic [DW-1:0]     bus [2];
  logic [2:0]        cnt [2];

  int checks;
  int fails;

  iq_entry_t mq [2][$];
  logic      pend [2];

  id_inst_queue #(.DATA_WD(DW), .DEPTH(DEP), .BYPASS(0)) dut0 (
    .clk(clk), .reset(reset),
    .fs_to_iq_valid(fs_valid), .fs_to_iq_bus(fs_bus), .iq_allowin(al[0]),
    .iq_to_ds_valid(v[0]), .iq_to_ds_bus(bus[0]), .ds_allowin(ds_allowin),
    .flush(flush), .br_redirect(br), .iq_count(cnt[0])
  );

  id_inst_queue #(.DATA_WD(DW), .DEPTH(DEP), .BYPASS(1)) dut1 (
    .clk(clk), .reset(reset),
    .fs_to_iq_valid(fs_valid), .fs_to_iq_bus(fs_bus), .iq_allowin(al[1]),
    .iq_to_ds_valid(v[1]), .iq_to_ds_bus(bus[1]), .ds_allowin(ds_allowin),
    .flush(flush), .br_redirect(br), .iq_count(cnt[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic iq_entry_t mk(input logic [31:0] pc);
    iq_entry_t e;
    e.ex.bd       = pc[3];
    e.ex.adel     = pc[2];
    e.ex.badvaddr = pc ^ 32'h5a5a_a5a5;
    e.ds.inst     = ~pc;
    e.ds.pc       = pc;
    return e;
  endfunction

  task automatic drive(input logic fv, input logic [31:0] pc, input logic dsa,
                       input logic fl, input logic b);
    fs_valid   = fv;
    fs_bus     = mk(pc);
    ds_allowin = dsa;
    flush      = fl;
    br         = b;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // --------------------------------------------------------------------------
  // Per-cycle compare against the model, then advance the model.
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    logic pa [2];
    pa[0] = dut0.ds_pending;
    pa[1] = dut1.ds_pending;
    for (int b = 0; b < 2; b++) begin
      int        n;
      logic      bp, ve, ae, pe, pop_e, drct;
      iq_entry_t keep;
      if (reset) begin
        chk($sformatf("u%0d reset valid", b), DW'(v[b]), DW'(0));
        chk($sformatf("u%0d reset count", b), DW'(cnt[b]), DW'(0));
        chk($sformatf("u%0d reset allowin", b), DW'(al[b]), DW'(1));
        mq[b].delete();
        pend[b] = 1'b0;
      end else begin
        n     = mq[b].size();
        bp    = (b == 1);
        ve    = (n != 0) || (bp && fs_valid);
        ae    = (n != DEP) || ds_allowin;
        pe    = fs_valid && ae;
        pop_e = ve && ds_allowin;
        drct  = bp && (n == 0) && fs_valid && ds_allowin;

        chk($sformatf("u%0d valid", b), DW'(v[b]), DW'(ve));
        chk($sformatf("u%0d allowin", b), DW'(al[b]), DW'(ae));
        chk($sformatf("u%0d count", b), DW'(cnt[b]), DW'(n));
        chk($sformatf("u%0d ds_pending", b), DW'(pa[b]), DW'(pend[b]));
        if (ve) chk($sformatf("u%0d head", b), bus[b], (n != 0) ? mq[b][0] : fs_bus);

        if (flush) begin
          mq[b].delete();
          pend[b] = 1'b0;
        end else if (drct) begin
          pend[b] = 1'b0;
        end else begin
          if (pop_e) void'(mq[b].pop_front());
          if (br && mq[b].size() >= 1) begin
            keep = mq[b][0];
            mq[b].delete();
            mq[b].push_back(keep);
            pend[b] = 1'b0;
          end else if (pe) begin
            mq[b].push_back(iq_entry_t'(fs_bus));
            pend[b] = 1'b0;
          end else if (br) begin
            pend[b] = 1'b1;
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Directed scenarios with literal expectations, then random traffic.
  // --------------------------------------------------------------------------
  initial begin
    checks = 0;
    fails  = 0;
    reset  = 1'b1;
    drive(0, 32'h0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #2;
    chk("lit reset valid", DW'(v[0]), DW'(0));
    chk("lit reset count", DW'(cnt[0]), DW'(0));
    chk("lit reset allowin", DW'(al[0]), DW'(1));
    nxt();

    // Fill to full with decode stalled, then drain in order.
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'hbfc0_0000 + 32'(4 * i), 0, 0, 0);
      nxt();
    end
    drive(0, 32'h0, 0, 0, 0);
    #2;
    chk("lit fill count", DW'(cnt[0]), DW'(4));
    chk("lit fill allowin", DW'(al[0]), DW'(0));
    chk("lit model size", DW'(mq[0].size()), DW'(4));
    nxt();
    for (int i = 0; i < 4; i++) begin
      drive(0, 32'h0, 1, 0, 0);
      #2;
      chk("lit drain valid", DW'(v[0]), DW'(1));
      chk("lit drain pc", DW'(bus[0][31:0]), DW'(32'hbfc0_0000 + 32'(4 * i)));
      nxt();
    end
    drive(0, 32'h0, 0, 0, 0);
    #2;
    chk("lit drained valid", DW'(v[0]), DW'(0));
    nxt();

    // Full queue with simultaneous push and pop.
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'ha0 + 32'(4 * i), 0, 0, 0);
      nxt();
    end
    drive(1, 32'hb0, 1, 0, 0);
    #2;
    chk("lit full allowin", DW'(al[0]), DW'(1));
    chk("lit full head", DW'(bus[0][31:0]), DW'(32'ha0));
    nxt();
    drive(0, 32'h0, 0, 0, 0);
    #2;
    chk("lit full count", DW'(cnt[0]), DW'(4));
    nxt();
    for (int i = 0; i < 4; i++) begin
      drive(0, 32'h0, 1, 0, 0);
      #2;
      chk("lit wrap pc", DW'(bus[0][31:0]), DW'(32'ha4 + 32'(4 * i)));
      nxt();
    end

    // Fall-through on the bypass instance.
    drive(1, 32'h100, 1, 0, 0);
    #2;
    chk("lit bypass valid", DW'(v[1]), DW'(1));
    chk("lit bypass pc", DW'(bus[1][31:0]), DW'(32'h100));
    chk("lit nobypass valid", DW'(v[0]), DW'(0));
    nxt();
    drive(0, 32'h0, 0, 0, 0);
    #2;
    chk("lit bypass count", DW'(cnt[1]), DW'(0));
    chk("lit nobypass count", DW'(cnt[0]), DW'(1));
    nxt();
    drive(0, 32'h0, 1, 0, 0);
    nxt();

    // Flush with a push in the same cycle.
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h50 + 32'(4 * i), 0, 0, 0);
      nxt();
    end
    drive(1, 32'h5c, 0, 1, 0);
    #2;
    chk("lit preflush count", DW'(cnt[0]), DW'(3));
    nxt();
    drive(0, 32'h0, 0, 0, 0);
    #2;
    chk("lit flush count", DW'(cnt[0]), DW'(0));
    chk("lit flush valid", DW'(v[0]), DW'(0));
    nxt();
    drive(1, 32'h60, 0, 0, 0);
    nxt();
    drive(0, 32'h0, 0, 0, 0);
    #2;
    chk("lit postflush pc", DW'(bus[0][31:0]), DW'(32'h60));
    nxt();
    drive(0, 32'h0, 1, 0, 0);
    nxt();

    // Redirect with entries: branch pops, delay slot survives.
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h200 + 32'(4 * i), 0, 0, 0);
      nxt();
    end
    drive(1, 32'h20c, 1, 0, 1);
    #2;
    chk("lit branch pc", DW'(bus[0][31:0]), DW'(32'h200));
    nxt();
    drive(0, 32'h0, 0, 0, 0);
    #2;
    chk("lit redirect count", DW'(cnt[0]), DW'(1));
    chk("lit delay slot pc", DW'(bus[0][31:0]), DW'(32'h204));
    nxt();
    drive(0, 32'h0, 1, 0, 0);
    nxt();
    drive(0, 32'h0, 0, 0, 0);
    #2;
    chk("lit squashed valid", DW'(v[0]), DW'(0));
    nxt();

    // Redirect while empty: delay slot still to come.
    drive(0, 32'h0, 0, 0, 1);
    nxt();
    drive(0, 32'h0, 0, 0, 0);
    #2;
    chk("lit pending set", DW'(dut0.ds_pending), DW'(1));
    nxt();
    drive(1, 32'h304, 0, 0, 0);
    nxt();
    drive(0, 32'h0, 0, 0, 0);
    #2;
    chk("lit pending clr", DW'(dut0.ds_pending), DW'(0));
    nxt();
    drive(1, 32'h400, 0, 0, 0);
    nxt();
    drive(0, 32'h0, 0, 0, 0);
    #2;
    chk("lit pending count", DW'(cnt[0]), DW'(2));
    chk("lit pending head", DW'(bus[0][31:0]), DW'(32'h304));
    nxt();
    drive(0, 32'h0, 1, 0, 0);
    nxt();
    nxt();

    // Asynchronous reset between clock edges.
    drive(1, 32'h500, 0, 0, 0);
    nxt();
    drive(1, 32'h504, 0, 0, 0);
    nxt();
    drive(0, 32'h0, 0, 0, 0);
    #1;
    chk("lit prereset count", DW'(cnt[0]), DW'(2));
    reset = 1'b1;
    #1;
    chk("lit async valid", DW'(v[0]), DW'(0));
    chk("lit async count", DW'(cnt[0]), DW'(0));
    chk("lit async count b", DW'(cnt[1]), DW'(0));
    nxt();
    reset = 1'b0;
    nxt();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 10) < 7, $urandom, ($urandom % 10) < 6,
            ($urandom % 40) == 0, ($urandom % 12) == 0);
      nxt();
    end
    drive(0, 32'h0, 0, 0, 0);
    nxt();
    nxt();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
